mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter: MUL_LAT, 18, cycles from the mul_start pulse to a valid mul_result (legal range 1..255).
REQ-002 SHALL have ports:
clk  input  1  rising-edge clock
n_rst  input  1  asynchronous active-low reset
req  input  2  per-requester level request, bit i = requester i
a0  input  16  requester 0 multiplicand (signed)
b0  input  16  requester 0 multiplier (signed)
a1  input  16  requester 1 multiplicand (signed)
b1  input  16  requester 1 multiplier (signed)
ack  output  2  one-cycle pulse: operands of requester i captured
done  output  2  one-cycle pulse: product for requester i valid on result
result  output  32  signed product, held until the next done
busy  output  1  high whenever state is not IDLE
mul_start  output  1  one-cycle start pulse to the shared multiplier
mul_m  output  16  multiplicand to multiplier
mul_q  output  16  multiplier to multiplier
mul_result  input  32  multiplier product
REQ-003 SHALL use one clock, clk; reset is asynchronous and active-low on n_rst.

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-005 IDLE: at a clk edge with req != 0, SHALL select grant g, latch a_g/b_g into mul_m/mul_q, record g, and go to ISSUE; with req == 0, SHALL stay in IDLE.
REQ-006 ISSUE (exactly one cycle): mul_start=1 and ack[g]=1; next state WAIT with wait counter loaded to MUL_LAT-1.
REQ-007 WAIT: counter SHALL decrement by 1 per cycle; at the edge where counter==0, SHALL capture mul_result into result and go to DONE.
REQ-008 DONE (exactly one cycle): done[g]=1; next state IDLE.
REQ-009 SHALL deliver done[g] exactly MUL_LAT+1 cycles after the ack[g] cycle.
REQ-010 mul_m/mul_q SHALL remain stable from ISSUE through DONE; input operand changes after ack SHALL have no effect.
REQ-011 req sampled only in IDLE; req bits that rise and fall outside IDLE SHALL be ignored (no queueing).
REQ-012 req held high through DONE SHALL start a new transaction from IDLE; minimum spacing between ack pulses is MUL_LAT+3 cycles.
REQ-013 At most one bit of ack and of done SHALL be high in any cycle; ack and done SHALL never be high together.
REQ-014 result SHALL change only at the edge entering DONE.

Reset
REQ-015 n_rst low SHALL immediately force: state IDLE, ack=0, done=0, result=0, busy=0, mul_start=0, mul_m=0, mul_q=0, counter=0, last-grant=1.
REQ-016 Reset during ISSUE/WAIT/DONE SHALL abort the transaction with no done pulse; first request after release is handled as from power-up.

Configuration
REQ-017 With macro MUL_ARB_RR_EN defined: round-robin; when req==2'b11, grant the requester not recorded as last grant; single request always granted; last-grant updated on every grant.
REQ-018 Without MUL_ARB_RR_EN: fixed priority, requester 0 wins whenever req[0]=1; last-grant register SHALL not be implemented.

Verification
REQ-019 MUL_LAT=18, req=01, a0=3, b0=-4 -> ack[0] one cycle after request edge, done[0] 19 cycles after ack, result=0xFFFFFFF4.
REQ-020 req=10, a1=0x7FFF, b1=0x7FFF -> mul_m=0x7FFF, mul_q=0x7FFF, done[1] with result=0x3FFF0001; ack[0]/done[0] never asserted.
REQ-021 req=11 held, RR_EN defined -> grants alternate 0,1,0,1; RR_EN undefined -> grants 0,0,0,0; ack spacing 21 cycles.
REQ-022 a0 changed from 5 to 9 in the cycle after ack[0] (b0=6) -> result=30, not 54.
REQ-023 n_rst pulsed low in WAIT, 5 cycles after ack -> all outputs 0 asynchronously, no done pulse; req=01 after release -> normal transaction, grant 0.

Source files
------------

// File: rtl/mul_arbiter.sv
// Two-requester front end for a shared fixed-latency signed multiplier.
// Define MUL_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module mul_arbiter #(
   parameter int MUL_LAT = 18
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic [1:0]  req,
   input  logic [15:0] a0,
   input  logic [15:0] b0,
   input  logic [15:0] a1,
   input  logic [15:0] b1,
   output logic [1:0]  ack,
   output logic [1:0]  done,
   output logic [31:0] result,
   output logic        busy,
   output logic        mul_start,
   output logic [15:0] mul_m,
   output logic [15:0] mul_q,
   input  logic [31:0] mul_result
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t     state;
   logic [7:0] cnt;
   logic       gsel;
   logic       grant;

`ifdef MUL_ARB_RR_EN
   logic last_grant;

   // On contention, hand the multiplier to whoever did not get it last time.
   always_comb begin
      grant = 1'b0;
      if (req == 2'b11) grant = ~last_grant;
      else              grant = ~req[0];
   end
`else
   always_comb begin
      grant = ~req[0];
   end
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         ack       <= 2'b00;
         done      <= 2'b00;
         result    <= 32'd0;
         busy      <= 1'b0;
         mul_start <= 1'b0;
         mul_m     <= 16'd0;
         mul_q     <= 16'd0;
         cnt       <= 8'd0;
         gsel      <= 1'b0;
`ifdef MUL_ARB_RR_EN
         last_grant <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               ack       <= 2'b00;
               done      <= 2'b00;
               mul_start <= 1'b0;
               busy      <= 1'b0;
               if (req != 2'b00) begin
                  gsel      <= grant;
                  mul_m     <= grant ? a1 : a0;
                  mul_q     <= grant ? b1 : b0;
                  ack       <= grant ? 2'b10 : 2'b01;
                  mul_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ISSUE;
`ifdef MUL_ARB_RR_EN
                  last_grant <= grant;
`endif
               end
            end
            ISSUE: begin
               ack       <= 2'b00;
               mul_start <= 1'b0;
               cnt       <= 8'(MUL_LAT - 1);
               state     <= WAIT;
            end
            WAIT: begin
               // Counter reaches zero exactly when the multiplier output becomes valid.
               if (cnt == 8'd0) begin
                  result <= mul_result;
                  done   <= gsel ? 2'b10 : 2'b01;
                  state  <= DONE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            DONE: begin
               done  <= 2'b00;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter with a behavioural fixed-latency multiplier.
// Expected grant/operands/product are queued at issue and checked by a monitor on ack/done.
module tb_mul_arbiter;

   localparam int MUL_LAT = 18;

   logic        clk = 1'b0;
   logic        n_rst;
   logic [1:0]  req;
   logic [15:0] a0, b0, a1, b1;
   logic [1:0]  ack, done;
   logic [31:0] result;
   logic        busy, mul_start;
   logic [15:0] mul_m, mul_q;
   logic [31:0] mul_result;

   typedef struct {
      logic        g;
      logic [15:0] m;
      logic [15:0] q;
      logic [31:0] r;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   ack_cyc = 0;

   logic [31:0] prod = 32'd0;
   int          mcnt = 0;

   mul_arbiter #(.MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .n_rst(n_rst), .req(req),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .ack(ack), .done(done), .result(result), .busy(busy),
      .mul_start(mul_start), .mul_m(mul_m), .mul_q(mul_q),
      .mul_result(mul_result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Product is only presented once MUL_LAT cycles have passed since the start pulse.
   always @(posedge clk) begin
      if (mul_start) begin
         prod <= $signed(mul_m) * $signed(mul_q);
         mcnt <= 1;
      end else if (mcnt < MUL_LAT) begin
         mcnt <= mcnt + 1;
      end
   end
   assign mul_result = (mcnt >= MUL_LAT) ? prod : 32'hDEADBEEF;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: timed out waiting for DUT", name);
   endtask

   always @(negedge clk) begin
      if (ack != 2'b00) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_ack", {62'd0, ack}, 64'd0);
         end else begin
            checkOutput("ack_grant", {62'd0, ack}, sb[0].g ? 64'd2 : 64'd1);
            checkOutput("ack_operands", {32'd0, mul_m, mul_q}, {32'd0, sb[0].m, sb[0].q});
            checkOutput("ack_start", {63'd0, mul_start}, 64'd1);
         end
         ack_cyc = cyc;
      end
      if (done != 2'b00) begin
         checkOutput("done_with_ack", {62'd0, ack}, 64'd0);
         if (sb.size() == 0) begin
            checkOutput("unexpected_done", {62'd0, done}, 64'd0);
         end else begin
            checkOutput("done_grant", {62'd0, done}, sb[0].g ? 64'd2 : 64'd1);
            checkOutput("done_result", {32'd0, result}, {32'd0, sb[0].r});
            checkOutput("done_latency", 64'(cyc - ack_cyc), 64'(MUL_LAT + 1));
            void'(sb.pop_front());
         end
      end
   end

   task automatic applyStimulus(input logic [1:0] r, input logic [15:0] ia0, input logic [15:0] ib0,
                                input logic [15:0] ia1, input logic [15:0] ib1);
      @(negedge clk);
      a0 = ia0; b0 = ib0; a1 = ia1; b1 = ib1;
      req = r;
   endtask

   task automatic waitAck(input string name, output int at);
      at = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (ack != 2'b00) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) timeoutFail(name);
   endtask

   task automatic waitIdle(input string name);
      bit ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (!busy && sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeoutFail(name);
   endtask

   task automatic doReset();
      @(negedge clk);
      n_rst = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int t;
      int prev;
      logic g;
      n_rst = 1'b0;
      req = 2'b00;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset_ack_done", {60'd0, ack, done}, 64'd0);
      checkOutput("reset_result", {32'd0, result}, 64'd0);
      checkOutput("reset_misc", {30'd0, busy, mul_start, mul_m, mul_q}, 64'd0);
      n_rst = 1'b1;

      // 3 * -4 on requester 0, ack must follow the request by one cycle
      sb.push_back('{g: 1'b0, m: 16'd3, q: 16'hFFFC, r: 32'hFFFFFFF4});
      applyStimulus(2'b01, 16'd3, 16'hFFFC, 16'd0, 16'd0);
      @(negedge clk);
      checkOutput("ack_latency", {62'd0, ack}, 64'd1);
      req = 2'b00;
      waitIdle("idle_after_t1");

      // Requester 1 only, max positive operands
      sb.push_back('{g: 1'b1, m: 16'h7FFF, q: 16'h7FFF, r: 32'h3FFF0001});
      applyStimulus(2'b10, 16'd1, 16'd1, 16'h7FFF, 16'h7FFF);
      waitAck("ack_t2", t);
      req = 2'b00;
      waitIdle("idle_after_t2");

      // Operand change after ack must not affect the product
      sb.push_back('{g: 1'b0, m: 16'd5, q: 16'd6, r: 32'd30});
      applyStimulus(2'b01, 16'd5, 16'd6, 16'd0, 16'd0);
      waitAck("ack_t3", t);
      a0 = 16'd9;
      req = 2'b00;
      waitIdle("idle_after_t3");

      // Both requesting continuously from a fresh reset
      doReset();
      for (int i = 0; i < 4; i++) begin
`ifdef MUL_ARB_RR_EN
         g = i[0];
`else
         g = 1'b0;
`endif
         if (g) sb.push_back('{g: 1'b1, m: 16'hFFF9, q: 16'hFFF8, r: 32'h00000038});
         else   sb.push_back('{g: 1'b0, m: 16'd100, q: 16'hFFFE, r: 32'hFFFFFF38});
      end
      applyStimulus(2'b11, 16'd100, 16'hFFFE, 16'hFFF9, 16'hFFF8);
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         waitAck("ack_both", t);
         if (i > 0 && t >= 0 && prev >= 0) checkOutput("ack_spacing", 64'(t - prev), 64'(MUL_LAT + 3));
         prev = t;
      end
      req = 2'b00;
      waitIdle("idle_after_both");

      // Reset in the middle of WAIT aborts silently
      sb.push_back('{g: 1'b0, m: 16'd2, q: 16'd2, r: 32'd4});
      applyStimulus(2'b01, 16'd2, 16'd2, 16'd0, 16'd0);
      waitAck("ack_t5", t);
      req = 2'b00;
      repeat (5) @(posedge clk);
      #2;
      n_rst = 1'b0;
      sb.delete();
      #1;
      checkOutput("abort_ack_done", {60'd0, ack, done}, 64'd0);
      checkOutput("abort_result", {32'd0, result}, 64'd0);
      checkOutput("abort_misc", {30'd0, busy, mul_start, mul_m, mul_q}, 64'd0);
      repeat (3) @(negedge clk);
      checkOutput("abort_no_done", {62'd0, done}, 64'd0);
      n_rst = 1'b1;

      sb.push_back('{g: 1'b0, m: 16'hFFFD, q: 16'd7, r: 32'hFFFFFFEB});
      applyStimulus(2'b01, 16'hFFFD, 16'd7, 16'd0, 16'd0);
      waitAck("ack_after_reset", t);
      req = 2'b00;
      waitIdle("idle_after_reset");

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
